mem_arbiter: RTL and testbench

- Single-port RAM arbiter directly downstream of the icache and dcache of one core.
- Accepts icache fill requests (iREN/iaddr) and dcache read/write requests, grants one at a time to the RAM, and returns wait/load handshakes to the requester.
- Data side has priority. A starvation counter guarantees instruction-fetch forward progress.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter sitting between the icache/dcache of
// one core and the RAM controller. One requester is granted at a time; the
// data side normally wins, but after STARVE_LIMIT data completions while an
// instruction fetch was waiting, the icache is forced to win the next round.
//
// Ports:
//   CLK, nRST               clock (rising edge), async active-low reset
//   iREN, iaddr             icache fill request and word address
//   iwait, iload            icache handshake (iwait low = done) and fill data
//   dREN, dWEN, daddr,      dcache read/write request, address, write data
//   dstore
//   dwait, dload            dcache handshake (dwait low = done) and read data
//   ramREN, ramWEN,         RAM request towards the controller
//   ramaddr, ramstore
//   ramload, ramstate       RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                     sticky: ERROR seen while a grant was active
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [1:0]       RAM_ERROR  = 2'd3;
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);

    state_t           state, next_state;
    logic [CNT_W-1:0] starve_cnt, next_cnt;
    logic             d_req;
    logic             access;
    logic             i_starved;

    // Counter saturates at the limit so a long data burst cannot wrap it
    // back below the threshold.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? v : v + CNT_W'(1);
    endfunction

    assign d_req     = dREN | dWEN;
    assign access    = (ramstate == RAM_ACCESS);
    assign i_starved = iREN && (starve_cnt >= LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
            if ((state != IDLE) && (ramstate == RAM_ERROR))
                err <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        iload      = '0;
        dwait      = 1'b1;
        dload      = '0;

        case (state)
            IDLE: begin
                if (!iREN)
                    next_cnt = '0;
                if (d_req && !i_starved)
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                if (!d_req) begin
                    // Requester gave up: enables already low, no handshake.
                    next_state = IDLE;
                end else if (access) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    next_state = IDLE;
                    if (iREN)
                        next_cnt = sat_inc(starve_cnt);
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (access) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    // Reference model: who currently owns the RAM (0 none, 1 icache,
    // 2 dcache), how many data transfers finished while a fetch waited,
    // and whether an error was ever observed during a grant.
    int owner;
    int streak;
    bit seen_err;

    task automatic model_reset();
        owner = 0; streak = 0; seen_err = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_next();
        if (!nRST) begin
            model_reset();
        end else if (owner == 0) begin
            if (!iREN) streak = 0;
            if ((dREN || dWEN) && !(iREN && streak >= LIMIT)) owner = 2;
            else if (iREN) owner = 1;
        end else begin
            if (ramstate == ERROR) seen_err = 1;
            if (owner == 2) begin
                if (!(dREN || dWEN)) owner = 0;
                else if (ramstate == ACCESS) begin
                    if (iREN && streak < LIMIT) streak++;
                    owner = 0;
                end
            end else begin
                if (!iREN) owner = 0;
                else if (ramstate == ACCESS) begin
                    streak = 0;
                    owner = 0;
                end
            end
        end
    endtask

    // Expected outputs packed as {iwait,iload,dwait,dload,ramREN,ramWEN,ramaddr,ramstore,err}.
    function automatic logic [132:0] model_out();
        logic        e_iw = 1, e_dw = 1, e_ren = 0, e_wen = 0;
        logic [31:0] e_il = 0, e_dl = 0, e_a = 0, e_s = 0;
        if (owner == 2) begin
            e_a = daddr; e_s = dstore; e_wen = dWEN; e_ren = dREN & ~dWEN;
            if ((dREN || dWEN) && ramstate == ACCESS) begin e_dw = 0; e_dl = ramload; end
        end else if (owner == 1) begin
            e_a = iaddr; e_ren = iREN;
            if (iREN && ramstate == ACCESS) begin e_iw = 0; e_il = ramload; end
        end
        return {e_iw, e_il, e_dw, e_dl, e_ren, e_wen, e_a, e_s, seen_err};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_next();
        @(negedge CLK);
    endtask

    task automatic set_in(input logic i, input logic [31:0] ia, input logic dr, input logic dw,
                          input logic [31:0] da, input logic [31:0] ds,
                          input logic [1:0] rs, input logic [31:0] rl);
        iREN = i; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        model_reset();
        @(negedge CLK);
        set_in(1, 32'hAAAA_0000, 1, 1, 32'h5555_0000, 32'hFFFF_FFFF, ACCESS, 32'h1111_2222);
        checks++;
        if ({ramREN, ramWEN, iwait, dwait, err} !== 5'b00110) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00110", {ramREN, ramWEN, iwait, dwait, err});
        end
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {ramaddr, ramstore, iload, dload});
        end
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_ifetch();
        set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0);
        checks++;
        if (ramREN !== 1'b0) begin failures++; $display("FAIL ifetch_arb_cycle ramREN=%b exp=0", ramREN); end
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
            checks++;
            if ({ramREN, iwait, ramaddr} !== {1'b1, 1'b1, 32'h40}) begin
                failures++;
                $display("FAIL ifetch_busy%0d got ren=%b iwait=%b addr=%h exp 1 1 00000040", k, ramREN, iwait, ramaddr);
            end
            tick();
        end
        set_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEAD_BEEF);
        checks++;
        if ({iwait, iload} !== {1'b0, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL ifetch_access got iwait=%b iload=%h exp 0 deadbeef", iwait, iload);
        end
        tick();
        set_in(0, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEAD_BEEF);
        checks++;
        if ({ramREN, iwait, iload} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL ifetch_idle_after got ren=%b iwait=%b iload=%h exp 0 1 0", ramREN, iwait, iload);
        end
        tick();
    endtask

    task automatic test_priority();
        set_in(1, 32'h80, 1, 0, 32'h300, 0, FREE, 0);
        tick();
        set_in(1, 32'h80, 1, 0, 32'h300, 0, BUSY, 0);
        checks++;
        if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h300, 1'b1}) begin
            failures++;
            $display("FAIL prio_dfirst got ren=%b addr=%h iwait=%b exp 1 00000300 1", ramREN, ramaddr, iwait);
        end
        tick();
        set_in(1, 32'h80, 1, 0, 32'h300, 0, ACCESS, 32'h55);
        checks++;
        if ({dwait, dload, iwait} !== {1'b0, 32'h55, 1'b1}) begin
            failures++;
            $display("FAIL prio_daccess got dwait=%b dload=%h iwait=%b exp 0 00000055 1", dwait, dload, iwait);
        end
        tick();
        set_in(1, 32'h80, 0, 0, 32'h300, 0, FREE, 0);
        checks++;
        if (ramREN !== 1'b0) begin failures++; $display("FAIL prio_gap ramREN=%b exp=0", ramREN); end
        tick();
        set_in(1, 32'h80, 0, 0, 32'h300, 0, ACCESS, 32'h66);
        checks++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h80, 1'b0, 32'h66}) begin
            failures++;
            $display("FAIL prio_ithen got ren=%b addr=%h iwait=%b iload=%h exp 1 00000080 0 00000066",
                     ramREN, ramaddr, iwait, iload);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        tick();
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 32'h4C, 0, 1, 32'h100 + 4 * k, 32'hC0 + k, FREE, 0);
            tick();
            set_in(1, 32'h4C, 0, 1, 32'h100 + 4 * k, 32'hC0 + k, ACCESS, 0);
            checks++;
            if ({ramWEN, ramaddr, dwait} !== {1'b1, 32'h100 + 4 * k, 1'b0}) begin
                failures++;
                $display("FAIL starve_write%0d got wen=%b addr=%h dwait=%b exp 1 %h 0",
                         k, ramWEN, ramaddr, dwait, 32'h100 + 4 * k);
            end
            tick();
        end
        set_in(1, 32'h4C, 0, 1, 32'h110, 32'hC4, FREE, 0);
        tick();
        set_in(1, 32'h4C, 0, 1, 32'h110, 32'hC4, ACCESS, 32'h99);
        checks++;
        if ({ramREN, ramWEN, ramaddr, iwait} !== {1'b1, 1'b0, 32'h4C, 1'b0}) begin
            failures++;
            $display("FAIL starve_iforced got ren=%b wen=%b addr=%h iwait=%b exp 1 0 0000004c 0",
                     ramREN, ramWEN, ramaddr, iwait);
        end
        tick();
        set_in(1, 32'h4C, 0, 1, 32'h110, 32'hC4, FREE, 0);
        tick();
        set_in(1, 32'h4C, 0, 1, 32'h110, 32'hC4, ACCESS, 0);
        checks++;
        if ({ramWEN, ramaddr, dwait} !== {1'b1, 32'h110, 1'b0}) begin
            failures++;
            $display("FAIL starve_cnt_cleared got wen=%b addr=%h dwait=%b exp 1 00000110 0", ramWEN, ramaddr, dwait);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        tick();
    endtask

    task automatic test_write_wins();
        set_in(0, 0, 1, 1, 32'h200, 32'h1234_5678, FREE, 0);
        tick();
        set_in(0, 0, 1, 1, 32'h200, 32'h1234_5678, BUSY, 0);
        checks++;
        if ({ramWEN, ramREN, ramstore, ramaddr, dwait} !== {1'b1, 1'b0, 32'h1234_5678, 32'h200, 1'b1}) begin
            failures++;
            $display("FAIL wr_wins got wen=%b ren=%b store=%h addr=%h dwait=%b exp 1 0 12345678 00000200 1",
                     ramWEN, ramREN, ramstore, ramaddr, dwait);
        end
        tick();
        set_in(0, 0, 1, 1, 32'h200, 32'h1234_5678, ACCESS, 0);
        checks++;
        if (dwait !== 1'b0) begin failures++; $display("FAIL wr_access dwait=%b exp=0", dwait); end
        tick();
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        tick();
    endtask

    task automatic test_abandon();
        set_in(1, 32'h500, 0, 0, 0, 0, FREE, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(1, 32'h500, 0, 0, 0, 0, BUSY, 0);
            tick();
        end
        set_in(0, 32'h500, 0, 0, 0, 0, BUSY, 0);
        checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            failures++;
            $display("FAIL abandon_drop got ren=%b iwait=%b exp 0 1", ramREN, iwait);
        end
        tick();
        set_in(1, 32'h500, 0, 0, 0, 0, ACCESS, 32'h77);
        checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            failures++;
            $display("FAIL abandon_idle got ren=%b iwait=%b exp 0 1", ramREN, iwait);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        tick();
    endtask

    task automatic test_error();
        set_in(0, 0, 1, 0, 32'h600, 0, FREE, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 1, 0, 32'h600, 0, ERROR, 32'hBAD);
            checks++;
            if ({dwait, ramREN, err} !== {1'b1, 1'b1, (k == 1) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL err_cycle%0d got dwait=%b ren=%b err=%b exp 1 1 %0d", k, dwait, ramREN, err, k);
            end
            tick();
        end
        set_in(0, 0, 1, 0, 32'h600, 0, ACCESS, 32'h77);
        checks++;
        if ({dwait, dload, err} !== {1'b0, 32'h77, 1'b1}) begin
            failures++;
            $display("FAIL err_access got dwait=%b dload=%h err=%b exp 0 00000077 1", dwait, dload, err);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky err=%b exp=1", err); end
        tick();
        // Reset in the middle of a fetch: enables must drop without a clock.
        set_in(1, 32'h700, 0, 0, 0, 0, FREE, 0);
        tick();
        set_in(1, 32'h700, 0, 0, 0, 0, ACCESS, 32'h88);
        nRST = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait, err, ramaddr, iload} !== {5'b00110, 64'd0}) begin
            failures++;
            $display("FAIL err_reset got ren=%b wen=%b iwait=%b dwait=%b err=%b addr=%h iload=%h exp 0 0 1 1 0 0 0",
                     ramREN, ramWEN, iwait, dwait, err, ramaddr, iload);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [132:0] exp_v;
        int r;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) iREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) dWEN = 1'($urandom_range(0, 1));
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 19);
            ramstate = (r < 8) ? BUSY : (r < 14) ? ACCESS : (r < 19) ? FREE : ERROR;
            nRST = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (!nRST) model_reset();
            #1;
            exp_v = model_out();
            checks++;
            if ({iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err} !== exp_v) begin
                failures++;
                $display("FAIL rnd_outputs cyc=%0d got=%h exp=%h", cyc,
                         {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err}, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_priority();
        test_starvation();
        test_write_wins();
        test_abandon();
        test_error();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
